script_stack_sequencer: RTL and testbench
=========================================

Name: script_stack_sequencer

Overview:
- Hardware operand stack and dispatch sequencer that sits directly upstream of AluScript. It replaces the software stack model used by the ALU benches.
- Accepts a stream of script instructions: literal pushes and ALU opcodes.
- For an ALU opcode: pops the required operands, drives the ALU input handshake, waits for done/error, then pushes the returned results.
- Reports stack depth and a sticky script error to the script controller.

Parameters:
- WIDTH, 512: stack word / ALU data width in bits.
- DEPTH, 16: stack entries; must be >= 2.
- TIMEOUT, 1024: maximum cycles to wait for alu_done or alu_error before a timeout error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ins_valid  in  1  instruction present.
- ins_ready  out  1  sequencer can accept an instruction.
- ins_is_push  in  1  1 = literal push, 0 = ALU opcode.
- ins_opcode  in  8  script opcode.
- ins_data  in  WIDTH  literal value; used only when ins_is_push = 1.
- opcode  out  8  opcode presented to the ALU.
- put_alu_in1  out  1  data_alu_in1 valid.
- put_alu_in2  out  1  data_alu_in2 valid.
- data_alu_in1  out  WIDTH  first operand (old top of stack).
- data_alu_in2  out  WIDTH  second operand (old top-1).
- done  in  1  ALU finished.
- error  in  1  ALU failed.
- put_alu_out1  in  1  data_alu_out1 valid.
- put_alu_out2  in  1  data_alu_out2 valid.
- data_alu_out1  in  WIDTH  first result.
- data_alu_out2  in  WIDTH  second result.
- depth  out  $clog2(DEPTH+1)  current entry count.
- busy  out  1  state != IDLE.
- script_err  out  1  sticky error flag.
- err_code  out  3  error cause: 0 none, 1 underflow, 2 overflow, 3 unknown opcode, 4 ALU error, 5 timeout.
- err_clear  in  1  synchronous clear of the error; empties the stack.

Behaviour:
- Reset (async): state IDLE, depth 0, all ALU-side outputs 0, opcode 8'h00, script_err 0, err_code 0.
- ins_ready = (state == IDLE) && !script_err. An instruction is accepted on a clock edge where ins_valid && ins_ready.
- Literal push:
  - If depth == DEPTH: overflow error and the stack is unchanged.
  - Otherwise ins_data becomes the new top at that edge and depth increments.
  - State stays IDLE, so back-to-back pushes are accepted at 1 per cycle.
- ALU opcode: arity comes from the package table.
  - Unknown opcode: error code 3.
  - depth < arity: error code 1 and the stack is unchanged.
  - Otherwise the sequencer goes to POP.
- POP (1 cycle):
  - Registers in1 = top and, if arity is 2, in2 = top-1.
  - Decrements depth by arity.
  - Goes to ISSUE.
- ISSUE (1 cycle):
  - Drives opcode, data_alu_in1/2 and put_alu_in1/2 (put_alu_in2 only when arity is 2).
  - Goes to WAIT.
- WAIT:
  - Holds opcode, data and put flags stable.
  - Counts cycles from 0.
  - If error is high: code 4. error has priority when done and error are high together.
  - Else if done is high: latches the out flags and data, drops the put_alu_in flags, goes to PUSH.
  - If the counter reaches TIMEOUT with neither: code 5.
- PUSH (1 cycle):
  - If put_alu_out1: push out1. Then if put_alu_out2: push out2, so out2 ends on top.
  - If the required free space (1 or 2) is missing: overflow error and no partial push.
  - Goes to IDLE.
- Any error:
  - Sets script_err and err_code, clears all put_alu_in flags, goes to ERR.
  - ERR holds until err_clear, which sets depth to 0, clears the error and returns to IDLE.
  - err_clear has no effect outside ERR.
- Reset asserted mid-operation (for example in WAIT): everything returns to reset values immediately, and stack contents are lost.
- Stack storage contents are don't-care above depth.
- depth updates are registered and visible on the cycle after the event.

Decomposition:
- Package script_pkg holds:
  - opcode constants: OP_DUP 8'h76, OP_DROP 8'h75, OP_SWAP 8'h7c, OP_EQUAL 8'h87, OP_ADD 8'h93, OP_CHECKSIG 8'hac;
  - err_code enum;
  - seq_state_t enum (IDLE, POP, ISSUE, WAIT, PUSH, ERR);
  - function op_arity(opcode) returning 0–2 plus a valid bit.
- One sub-module, script_lifo: a register-array LIFO with pop-1/pop-2 and push-1/push-2 ports, exposing top, top-1 and count. The FSM stays in script_stack_sequencer.

Test Plan:
1. Push 'hDEAD_BEEF, then OP_DUP with an ALU model returning out1 = out2 = in1 → ALU sees put_alu_in1 = 1, put_alu_in2 = 0, data 'hDEAD_BEEF; afterwards depth 2, both entries 'hDEAD_BEEF.
2. Repeat OP_DUP a second time → depth 3, all entries 'hDEAD_BEEF, no error.
3. Push 1, push 2, OP_ADD with the model returning out1 = in1 + in2 → in1 = 2, in2 = 1; depth 1, top 3.
4. Empty stack, OP_DUP → script_err = 1, err_code 1, ALU is never issued, ins_ready = 0. After err_clear: depth 0, ins_ready = 1.
5. DEPTH pushes followed by one more push → err_code 2, depth stays DEPTH. Separately, the ALU asserts error in WAIT → err_code 4.
6. The ALU never responds → err_code 5 after TIMEOUT cycles. In a separate run, assert rst during WAIT → depth 0, put_alu_in1 = 0, busy = 0 within the same cycle.

Source files
------------

// File: rtl/script_stack_sequencer_pkg.sv
// script_pkg: shared definitions for the script stack sequencer.
//   - Script opcode constants understood by the sequencer.
//   - err_code_t: cause reported on err_code.
//   - seq_state_t: sequencer FSM states.
//   - op_arity(): operand count (0..2) plus a known-opcode bit.
package script_pkg;

    localparam logic [7:0] OP_DUP      = 8'h76;
    localparam logic [7:0] OP_DROP     = 8'h75;
    localparam logic [7:0] OP_SWAP     = 8'h7c;
    localparam logic [7:0] OP_EQUAL    = 8'h87;
    localparam logic [7:0] OP_ADD      = 8'h93;
    localparam logic [7:0] OP_CHECKSIG = 8'hac;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_UNDERFLOW  = 3'd1,
        ERR_OVERFLOW   = 3'd2,
        ERR_UNKNOWN_OP = 3'd3,
        ERR_ALU        = 3'd4,
        ERR_TIMEOUT    = 3'd5
    } err_code_t;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        ISSUE,
        WAIT,
        PUSH,
        ERR
    } seq_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] arity;
    } op_info_t;

    function automatic op_info_t op_arity(input logic [7:0] op);
        op_info_t info;
        info.valid = 1'b1;
        info.arity = 2'd0;
        case (op)
            OP_DUP, OP_DROP:                        info.arity = 2'd1;
            OP_SWAP, OP_EQUAL, OP_ADD, OP_CHECKSIG: info.arity = 2'd2;
            default:                                info.valid = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/script_stack_sequencer_lifo.sv
// script_lifo: register-array operand stack.
//   clk, rst       : clock, asynchronous active-high reset (count only)
//   clear_i        : empty the stack (highest priority)
//   pop_n_i        : number of entries to pop this cycle (0..2)
//   push_n_i       : number of entries to push this cycle (0..2)
//   push_a_i       : first word pushed
//   push_b_i       : second word pushed; ends on top when push_n_i == 2
//   top_o, top1_o  : current top and top-1 (don't-care when not present)
//   count_o        : current entry count
// Pops are applied before pushes in the same cycle. The caller guarantees
// it never pops more than count or pushes past DEPTH.
module script_lifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_i,
    input  logic [1:0]                     pop_n_i,
    input  logic [1:0]                     push_n_i,
    input  logic [WIDTH-1:0]               push_a_i,
    input  logic [WIDTH-1:0]               push_b_i,
    output logic [WIDTH-1:0]               top_o,
    output logic [WIDTH-1:0]               top1_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    base;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    top1_idx;

    // Write base is the count after this cycle's pop.
    assign base = count_q - CW'(pop_n_i);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else begin
            count_d = base + CW'(push_n_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage carries no reset; entries above count are don't-care.
    always_ff @(posedge clk) begin
        if (!clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((push_n_i != 2'd0) && (CW'(i) == base)) begin
                    mem_q[i] <= push_a_i;
                end else if ((push_n_i == 2'd2) && (CW'(i) == base + CW'(1))) begin
                    mem_q[i] <= push_b_i;
                end
            end
        end
    end

    assign top_idx  = AW'(count_q) - AW'(1);
    assign top1_idx = AW'(count_q) - AW'(2);
    assign top_o    = mem_q[top_idx];
    assign top1_o   = mem_q[top1_idx];
    assign count_o  = count_q;

endmodule

// File: rtl/script_stack_sequencer.sv
// script_stack_sequencer: operand stack and dispatch sequencer in front of
// the script ALU.
//   clk, rst                 : clock, asynchronous active-high reset
//   ins_valid/ins_ready      : instruction handshake
//   ins_is_push              : 1 = literal push of ins_data, 0 = ALU opcode
//   ins_opcode, ins_data     : instruction payload
//   opcode, put_alu_in1/2,
//   data_alu_in1/2           : registered ALU request (in1 = old top)
//   done, error              : ALU completion / failure
//   put_alu_out1/2,
//   data_alu_out1/2          : ALU results, pushed out1 then out2
//   depth                    : stack entry count
//   busy                     : FSM not idle
//   script_err, err_code     : sticky error flag and cause
//   err_clear                : leaves ERR, empties the stack
module script_stack_sequencer
    import script_pkg::*;
#(
    parameter int WIDTH   = 512,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ins_valid,
    output logic                       ins_ready,
    input  logic                       ins_is_push,
    input  logic [7:0]                 ins_opcode,
    input  logic [WIDTH-1:0]           ins_data,
    output logic [7:0]                 opcode,
    output logic                       put_alu_in1,
    output logic                       put_alu_in2,
    output logic [WIDTH-1:0]           data_alu_in1,
    output logic [WIDTH-1:0]           data_alu_in2,
    input  logic                       done,
    input  logic                       error,
    input  logic                       put_alu_out1,
    input  logic                       put_alu_out2,
    input  logic [WIDTH-1:0]           data_alu_out1,
    input  logic [WIDTH-1:0]           data_alu_out2,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       busy,
    output logic                       script_err,
    output logic [2:0]                 err_code,
    input  logic                       err_clear
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;

    seq_state_t       state_q;
    logic [7:0]       op_pend_q;
    logic [7:0]       opcode_q;
    logic [1:0]       arity_q;
    logic [WIDTH-1:0] in1_q;
    logic [WIDTH-1:0] in2_q;
    logic             put1_q;
    logic             put2_q;
    logic             out_v1_q;
    logic             out_v2_q;
    logic [WIDTH-1:0] out1_q;
    logic [WIDTH-1:0] out2_q;
    logic [TW-1:0]    timer_q;
    logic             err_q;
    err_code_t        code_q;

    logic [WIDTH-1:0] lifo_top;
    logic [WIDTH-1:0] lifo_top1;
    logic [CW-1:0]    lifo_count;
    logic [1:0]       pop_n;
    logic [1:0]       push_n;
    logic [WIDTH-1:0] push_a;
    logic [WIDTH-1:0] push_b;
    logic             lifo_clear;

    logic             accept;
    op_info_t         info;
    logic             full;
    logic [1:0]       need;
    logic             push_room;
    logic             fault;
    err_code_t        fault_code;

    assign ins_ready = (state_q == IDLE) && !err_q;
    assign accept    = ins_valid && ins_ready;
    assign info      = op_arity(ins_opcode);
    assign full      = (lifo_count == CW'(DEPTH));
    assign need      = {1'b0, out_v1_q} + {1'b0, out_v2_q};
    // One extra bit so count + 2 cannot wrap for any DEPTH.
    assign push_room = ({1'b0, lifo_count} + (CW+1)'(need)) <= (CW+1)'(DEPTH);

    // Error detection, shared by every state that can fault.
    always_comb begin
        fault      = 1'b0;
        fault_code = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ins_is_push) begin
                        if (full) begin
                            fault      = 1'b1;
                            fault_code = ERR_OVERFLOW;
                        end
                    end else if (!info.valid) begin
                        fault      = 1'b1;
                        fault_code = ERR_UNKNOWN_OP;
                    end else if (lifo_count < CW'(info.arity)) begin
                        fault      = 1'b1;
                        fault_code = ERR_UNDERFLOW;
                    end
                end
            end
            WAIT: begin
                // error wins over a simultaneous done.
                if (error) begin
                    fault      = 1'b1;
                    fault_code = ERR_ALU;
                end else if (!done && (timer_q == TW'(TIMEOUT - 1))) begin
                    fault      = 1'b1;
                    fault_code = ERR_TIMEOUT;
                end
            end
            PUSH: begin
                if (!push_room) begin
                    fault      = 1'b1;
                    fault_code = ERR_OVERFLOW;
                end
            end
            default: ;
        endcase
    end

    // Stack control: literal pushes land on the accepting edge, ALU operands
    // leave in POP, ALU results enter in PUSH only when both fit.
    always_comb begin
        pop_n      = 2'd0;
        push_n     = 2'd0;
        push_a     = ins_data;
        push_b     = out2_q;
        lifo_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && ins_is_push && !full) begin
                    push_n = 2'd1;
                end
            end
            POP: begin
                pop_n = arity_q;
            end
            PUSH: begin
                if (push_room) begin
                    push_n = need;
                    push_a = out_v1_q ? out1_q : out2_q;
                end
            end
            ERR: begin
                lifo_clear = err_clear;
            end
            default: ;
        endcase
    end

    script_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (lifo_clear),
        .pop_n_i  (pop_n),
        .push_n_i (push_n),
        .push_a_i (push_a),
        .push_b_i (push_b),
        .top_o    (lifo_top),
        .top1_o   (lifo_top1),
        .count_o  (lifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_pend_q <= 8'h00;
            opcode_q  <= 8'h00;
            arity_q   <= 2'd0;
            in1_q     <= '0;
            in2_q     <= '0;
            put1_q    <= 1'b0;
            put2_q    <= 1'b0;
            out_v1_q  <= 1'b0;
            out_v2_q  <= 1'b0;
            out1_q    <= '0;
            out2_q    <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
        end else if (fault) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            code_q  <= fault_code;
            put1_q  <= 1'b0;
            put2_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && !ins_is_push) begin
                        op_pend_q <= ins_opcode;
                        arity_q   <= info.arity;
                        state_q   <= POP;
                    end
                end
                // POP -> ISSUE: capture operands before the stack drops them.
                POP: begin
                    in1_q   <= lifo_top;
                    in2_q   <= (arity_q == 2'd2) ? lifo_top1 : '0;
                    state_q <= ISSUE;
                end
                // ISSUE -> WAIT: present the request to the ALU.
                ISSUE: begin
                    opcode_q <= op_pend_q;
                    put1_q   <= 1'b1;
                    put2_q   <= (arity_q == 2'd2);
                    timer_q  <= '0;
                    state_q  <= WAIT;
                end
                // WAIT -> PUSH: capture results on done.
                WAIT: begin
                    if (done) begin
                        out_v1_q <= put_alu_out1;
                        out_v2_q <= put_alu_out2;
                        out1_q   <= data_alu_out1;
                        out2_q   <= data_alu_out2;
                        put1_q   <= 1'b0;
                        put2_q   <= 1'b0;
                        state_q  <= PUSH;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                PUSH: begin
                    state_q <= IDLE;
                end
                ERR: begin
                    if (err_clear) begin
                        err_q   <= 1'b0;
                        code_q  <= ERR_NONE;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign opcode       = opcode_q;
    assign put_alu_in1  = put1_q;
    assign put_alu_in2  = put2_q;
    assign data_alu_in1 = in1_q;
    assign data_alu_in2 = in2_q;
    assign depth        = lifo_count;
    assign busy         = (state_q != IDLE);
    assign script_err   = err_q;
    assign err_code     = code_q;

endmodule

// File: tb/tb_script_stack_sequencer.sv
module tb_script_stack_sequencer;
    import script_pkg::*;

    localparam int W  = 64;
    localparam int D  = 8;
    localparam int TO = 20;
    localparam int CW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          ins_valid, ins_ready, ins_is_push;
    logic [7:0]    ins_opcode, opcode;
    logic [W-1:0]  ins_data;
    logic          put_alu_in1, put_alu_in2;
    logic [W-1:0]  data_alu_in1, data_alu_in2;
    logic          done, error, put_alu_out1, put_alu_out2;
    logic [W-1:0]  data_alu_out1, data_alu_out2;
    logic [CW-1:0] depth;
    logic          busy, script_err, err_clear;
    logic [2:0]    err_code;

    script_stack_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_is_push(ins_is_push),
        .ins_opcode(ins_opcode), .ins_data(ins_data),
        .opcode(opcode), .put_alu_in1(put_alu_in1), .put_alu_in2(put_alu_in2),
        .data_alu_in1(data_alu_in1), .data_alu_in2(data_alu_in2),
        .done(done), .error(error),
        .put_alu_out1(put_alu_out1), .put_alu_out2(put_alu_out2),
        .data_alu_out1(data_alu_out1), .data_alu_out2(data_alu_out2),
        .depth(depth), .busy(busy), .script_err(script_err),
        .err_code(err_code), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: script stack as a queue (back = top) plus sticky error.
    logic [W-1:0] st[$];
    bit           m_err = 1'b0;
    int           m_code = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_arity(input logic [7:0] op);
        case (op)
            OP_DUP, OP_DROP:                        return 1;
            OP_SWAP, OP_EQUAL, OP_ADD, OP_CHECKSIG: return 2;
            default:                                return -1;
        endcase
    endfunction

    task automatic check_status(input string tag);
        check({tag, "_depth"}, W'(depth), W'(st.size()));
        check({tag, "_err"}, W'(script_err), W'(m_err));
        check({tag, "_code"}, W'(err_code), W'(m_code));
    endtask

    task automatic do_push(input logic [W-1:0] v);
        @(negedge clk);
        check("push_ready", W'(ins_ready), W'(1));
        ins_valid = 1'b1; ins_is_push = 1'b1; ins_data = v;
        @(posedge clk); #1;
        ins_valid = 1'b0;
        if (st.size() == D) begin
            m_err = 1'b1; m_code = 2;
        end else begin
            st.push_back(v);
        end
        @(negedge clk);
        check_status("push");
    endtask

    // mode: 0 = ALU done, 1 = ALU error, 2 = ALU silent, 3 = reset during WAIT
    task automatic do_op(input logic [7:0] op, input int mode);
        int ar;
        int k;
        logic [W-1:0] a, b;
        logic [W-1:0] res[$];
        ar = model_arity(op);
        a = (st.size() > 0) ? st[st.size()-1] : '0;
        b = (st.size() > 1) ? st[st.size()-2] : '0;
        @(negedge clk);
        check("op_ready", W'(ins_ready), W'(1));
        ins_valid = 1'b1; ins_is_push = 1'b0; ins_opcode = op; ins_data = {$urandom(), $urandom()};
        @(posedge clk); #1;
        ins_valid = 1'b0;
        if (ar < 0 || st.size() < ar) begin
            m_err = 1'b1; m_code = (ar < 0) ? 3 : 1;
            @(negedge clk);
            check_status("decode");
            check("decode_ready", W'(ins_ready), W'(0));
            repeat (3) @(negedge clk);
            check("never_issued", W'(put_alu_in1), W'(0));
            return;
        end
        k = 0;
        while (!put_alu_in1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("issue_seen", W'(put_alu_in1), W'(1));
        repeat (ar) void'(st.pop_back());
        check("issue_opcode", W'(opcode), W'(op));
        check("issue_in1", data_alu_in1, a);
        check("issue_put2", W'(put_alu_in2), W'(ar == 2));
        if (ar == 2) check("issue_in2", data_alu_in2, b);
        check("wait_depth", W'(depth), W'(st.size()));
        check("wait_busy", W'(busy), W'(1));

        if (mode == 2) begin
            k = 0;
            while (!script_err && k < TO + 10) begin
                @(negedge clk);
                k++;
            end
            check("timeout_cycles", W'(k), W'(TO));
            m_err = 1'b1; m_code = 5;
            check_status("timeout");
            check("timeout_put1", W'(put_alu_in1), W'(0));
            return;
        end
        if (mode == 3) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            st.delete(); m_err = 1'b0; m_code = 0;
            check_status("midrst");
            check("midrst_put1", W'(put_alu_in1), W'(0));
            check("midrst_busy", W'(busy), W'(0));
            @(negedge clk);
            rst = 1'b0;
            return;
        end

        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("put_hold", W'(put_alu_in1), W'(1));
        // ALU stand-in: produce results for the presented operands.
        put_alu_out1 = 1'b0; put_alu_out2 = 1'b0;
        data_alu_out1 = {$urandom(), $urandom()}; data_alu_out2 = {$urandom(), $urandom()};
        case (op)
            OP_DUP:      begin put_alu_out1 = 1; put_alu_out2 = 1; data_alu_out1 = a; data_alu_out2 = a; end
            OP_SWAP:     begin put_alu_out1 = 1; put_alu_out2 = 1; data_alu_out1 = a; data_alu_out2 = b; end
            OP_EQUAL:    begin put_alu_out1 = 1; data_alu_out1 = W'(a == b); end
            OP_ADD:      begin put_alu_out1 = 1; data_alu_out1 = a + b; end
            OP_CHECKSIG: begin put_alu_out1 = 1; data_alu_out1 = a ^ b; end
            default: ;
        endcase
        if (mode == 1) begin
            error = 1'b1;
            done  = ($urandom_range(0, 1) == 1);
        end else begin
            done = 1'b1;
        end
        @(posedge clk); #1;
        done = 1'b0; error = 1'b0; put_alu_out1 = 1'b0; put_alu_out2 = 1'b0;
        if (mode == 1) begin
            m_err = 1'b1; m_code = 4;
            @(negedge clk);
            check_status("alu_err");
            check("alu_err_put1", W'(put_alu_in1), W'(0));
            return;
        end
        // Expected stack effect of each script word.
        case (op)
            OP_DUP:      begin res.push_back(a); res.push_back(a); end
            OP_SWAP:     begin res.push_back(a); res.push_back(b); end
            OP_EQUAL:    res.push_back((a == b) ? W'(1) : W'(0));
            OP_ADD:      res.push_back(a + b);
            OP_CHECKSIG: res.push_back(a ^ b);
            default: ;
        endcase
        if (st.size() + res.size() > D) begin
            m_err = 1'b1; m_code = 2;
        end else begin
            foreach (res[i]) st.push_back(res[i]);
        end
        @(negedge clk);
        check("push_put1", W'(put_alu_in1), W'(0));
        @(negedge clk);
        check_status("result");
        check("result_busy", W'(busy), W'(m_err));
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        st.delete(); m_err = 1'b0; m_code = 0;
        @(negedge clk);
        check_status("clear");
        check("clear_ready", W'(ins_ready), W'(1));
    endtask

    logic [7:0] ops[7] = '{OP_DUP, OP_DROP, OP_SWAP, OP_EQUAL, OP_ADD, OP_CHECKSIG, 8'h00};

    initial begin
        rst = 1'b1; ins_valid = 0; ins_is_push = 0; ins_opcode = 0; ins_data = 0;
        done = 0; error = 0; put_alu_out1 = 0; put_alu_out2 = 0;
        data_alu_out1 = 0; data_alu_out2 = 0; err_clear = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_status("reset");
        check("reset_busy", W'(busy), W'(0));
        check("reset_put1", W'(put_alu_in1), W'(0));
        check("reset_put2", W'(put_alu_in2), W'(0));
        check("reset_opcode", W'(opcode), W'(0));
        check("reset_ready", W'(ins_ready), W'(1));

        // DUP twice, then read entries back through DROP operands.
        do_push(W'(32'hDEAD_BEEF));
        do_op(OP_DUP, 0);
        do_op(OP_DUP, 0);
        repeat (3) do_op(OP_DROP, 0);

        // ADD operand order and result.
        do_push(W'(1));
        do_push(W'(2));
        do_op(OP_ADD, 0);
        do_op(OP_DROP, 0);

        // Underflow on empty stack.
        do_op(OP_DUP, 0);
        clear_err();

        // Back-to-back pushes at one per cycle.
        @(negedge clk);
        ins_valid = 1'b1; ins_is_push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ins_data = W'(100 + i);
            @(posedge clk); #1;
            st.push_back(W'(100 + i));
        end
        ins_valid = 1'b0;
        @(negedge clk);
        check_status("burst");

        // err_clear outside ERR is ignored.
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        @(negedge clk);
        check_status("stray_clear");
        do_op(OP_SWAP, 0);
        do_op(OP_DROP, 0);
        do_op(OP_DROP, 0);
        do_op(OP_DROP, 0);

        // Overflow on a full stack, then DUP overflow at PUSH.
        for (int i = 0; i < D; i++) do_push({$urandom(), $urandom()});
        do_push(W'(7));
        clear_err();
        for (int i = 0; i < D; i++) do_push({$urandom(), $urandom()});
        do_op(OP_DUP, 0);
        clear_err();

        // Unknown opcode, ALU error, timeout, reset in WAIT.
        do_push(W'(5));
        do_op(8'h00, 0);
        clear_err();
        do_push(W'(6));
        do_op(OP_DUP, 1);
        clear_err();
        do_push(W'(8));
        do_op(OP_DUP, 2);
        clear_err();
        do_push(W'(9));
        do_op(OP_DUP, 3);

        // Randomised script traffic.
        for (int n = 0; n < 300; n++) begin
            if (m_err) clear_err();
            if ($urandom_range(0, 99) < 40) begin
                do_push({$urandom(), $urandom()});
            end else begin
                do_op(ops[$urandom_range(0, ($urandom_range(0, 9) == 0) ? 6 : 5)],
                      ($urandom_range(0, 19) == 0) ? 1 : 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
